frame_ram_arbiter: RTL and testbench

Shares the single-port frame-buffer RAM between the VGA pixel fetch path (reader) and the UART-fed frame loader (writer). Every cycle it grants the RAM to at most one requester and drives the RAM address, data and write-enable from the winner. It returns read data with a fixed, known latency. It sits between the RAM and both RAM clients in the VGA serial display design.

---
 rtl/frame_ram_arbiter.sv | 104 ++++++++++
 tb/tb_frame_ram_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ram_arbiter.sv
// Single-port frame-buffer RAM arbiter between the VGA reader and the UART frame loader.
// Optional writer starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module frame_ram_arbiter #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_W     = 17,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 visible,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [RAM_WIDTH-1:0] rd_data,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [RAM_WIDTH-1:0] wr_data,
  output logic                 wr_gnt,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  input  logic [RAM_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, OWN_RD, OWN_WR} owner_e;

  owner_e                state;
  logic                  force_wr;
  logic [RD_LATENCY:0]   vpipe;

`ifdef ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign force_wr = wr_req && (wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (!wr_req || wr_gnt)
      wait_cnt <= '0;
    else if (wait_cnt != WAIT_W'(MAX_WAIT))
      wait_cnt <= wait_cnt + WAIT_W'(1);
  end
`else
  logic unused_max_wait;

  assign force_wr        = 1'b0;
  assign unused_max_wait = (MAX_WAIT != 0);
`endif

  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (force_wr)
      wr_gnt = 1'b1;
    else if (visible) begin
      if (rd_req)      rd_gnt = 1'b1;
      else if (wr_req) wr_gnt = 1'b1;
    end else begin
      if (wr_req)      wr_gnt = 1'b1;
      else if (rd_req) rd_gnt = 1'b1;
    end
  end

  // Owner state is the registered grant, so ram_en/ram_we decode straight from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (rd_gnt) begin
      state     <= OWN_RD;
      ram_addr  <= rd_addr;
      ram_wdata <= '0;
    end else if (wr_gnt) begin
      state     <= OWN_WR;
      ram_addr  <= wr_addr;
      ram_wdata <= wr_data;
    end else begin
      state     <= IDLE;
    end
  end

  assign ram_en = (state != IDLE);
  assign ram_we = (state == OWN_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vpipe <= '0;
    else begin
      vpipe[0] <= rd_gnt;
      for (int unsigned i = 1; i <= RD_LATENCY; i++)
        vpipe[i] <= vpipe[i-1];
    end
  end

  assign rd_valid = vpipe[RD_LATENCY];
  assign rd_data  = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Self-checking bench for frame_ram_arbiter: grant table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_frame_ram_arbiter;
  localparam int RAM_WIDTH  = 32;
  localparam int ADDR_W     = 17;
  localparam int RD_LATENCY = 1;
  localparam int MAX_WAIT   = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 visible = 1'b0;
  logic                 rd_req = 1'b0;
  logic [ADDR_W-1:0]    rd_addr = '0;
  logic                 rd_gnt, rd_valid, wr_gnt, ram_en, ram_we;
  logic [RAM_WIDTH-1:0] rd_data, ram_wdata;
  logic                 wr_req = 1'b0;
  logic [ADDR_W-1:0]    wr_addr = '0;
  logic [RAM_WIDTH-1:0] wr_data = '0;
  logic [ADDR_W-1:0]    ram_addr;
  logic [RAM_WIDTH-1:0] ram_rdata = '0;

  frame_ram_arbiter #(
    .RAM_WIDTH(RAM_WIDTH), .ADDR_W(ADDR_W), .RD_LATENCY(RD_LATENCY), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .visible(visible),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM with one cycle of read latency
  logic [RAM_WIDTH-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr[7:0]];
    end
  end

  // Reference model state
  typedef struct { int due; logic [RAM_WIDTH-1:0] data; } ret_t;
  ret_t                 rq[$];
  logic [RAM_WIDTH-1:0] ref_mem [256];
  bit                   m_en, m_we;
  logic [ADDR_W-1:0]    m_addr;
  logic [RAM_WIDTH-1:0] m_wdata;
  int                   m_denied;
  int                   cyc;

  int n_vec = 0;
  int n_err = 0;
  bit s_rd, s_wr, s_we;
  logic [ADDR_W-1:0] s_addr;

  typedef struct { bit vis, rd, wr, e_rd, e_wr; } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_denied = 0;
  endtask

  // Called at a falling edge with inputs applied; checks this cycle and advances one clock.
  task automatic run_cycle();
    bit g_rd, g_wr, fw, e_valid;
    logic [RAM_WIDTH-1:0] e_data;
    #1;
    fw = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    fw = wr_req && (m_denied == MAX_WAIT);
`endif
    g_wr = fw || (wr_req && (!visible || !rd_req));
    g_rd = !g_wr && rd_req;
    e_valid = (rq.size() > 0) && (rq[0].due == cyc);
    e_data  = e_valid ? rq[0].data : '0;
    if (e_valid) void'(rq.pop_front());
    s_rd = rd_gnt; s_wr = wr_gnt; s_we = ram_we; s_addr = ram_addr;
    chk("rd_gnt", rd_gnt, g_rd);
    chk("wr_gnt", wr_gnt, g_wr);
    chk("ram_en", ram_en, m_en);
    chk("ram_we", ram_we, m_we);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("rd_valid", rd_valid, e_valid);
    chk("rd_data", rd_data, e_data);
    m_en = g_rd || g_wr;
    m_we = g_wr;
    if (g_rd) begin
      rq.push_back('{cyc + 1 + RD_LATENCY, ref_mem[rd_addr[7:0]]});
      m_addr = rd_addr; m_wdata = '0;
    end
    if (g_wr) begin
      ref_mem[wr_addr[7:0]] = wr_data;
      m_addr = wr_addr; m_wdata = wr_data;
    end
    if (wr_req && !g_wr) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
    else                 m_denied = 0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first_wr;
    tbl[0] = '{0,0,0, 0,0}; tbl[1] = '{0,0,1, 0,1};
    tbl[2] = '{0,1,0, 1,0}; tbl[3] = '{0,1,1, 0,1};
    tbl[4] = '{1,0,0, 0,0}; tbl[5] = '{1,0,1, 0,1};
    tbl[6] = '{1,1,0, 1,0}; tbl[7] = '{1,1,1, 1,0};
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA500_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
    end
    model_reset();
    cyc = 0;

    // Reset values; grants stay combinational during reset
    #12;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    visible = 1; rd_req = 1; #1;
    chk("rst_rd_gnt_comb", rd_gnt, 1);
    rd_req = 0; visible = 0;
    @(negedge clk); rst = 0;

    // Grant truth table
    foreach (tbl[i]) begin
      visible = tbl[i].vis; rd_req = tbl[i].rd; wr_req = tbl[i].wr;
      rd_addr = ADDR_W'(30 + i); wr_addr = ADDR_W'(40 + i); wr_data = $urandom;
      run_cycle();
      chk("tbl_rd_gnt", s_rd, tbl[i].e_rd);
      chk("tbl_wr_gnt", s_wr, tbl[i].e_wr);
    end
    rd_req = 0; wr_req = 0; run_cycle(); run_cycle(); run_cycle();

    // Read priority while visible, writer pending
    visible = 1; wr_req = 1; wr_addr = 200; wr_data = 32'h1234_5678; rd_req = 1;
    for (int a = 5; a <= 7; a++) begin
      rd_addr = ADDR_W'(a);
      run_cycle();
      chk("rdprio_rd_gnt", s_rd, 1);
      chk("rdprio_wr_gnt", s_wr, 0);
    end
    rd_req = 0; wr_req = 0; run_cycle(); run_cycle(); run_cycle();

    // Blanking: writer first, read follows, then read back the written word
    visible = 0; rd_req = 1; rd_addr = 101; wr_req = 1; wr_addr = 100; wr_data = 32'hDEAD_BEEF;
    run_cycle();
    chk("blank_wr_gnt", s_wr, 1);
    chk("blank_rd_held", s_rd, 0);
    wr_req = 0;
    run_cycle();
    chk("blank_ram_we", s_we, 1);
    chk("blank_ram_addr", s_addr, 100);
    chk("blank_rd_gnt", s_rd, 1);
    rd_addr = 100; run_cycle();
    rd_req = 0; run_cycle(); run_cycle(); run_cycle();

    // Writer starvation under continuous reads
    visible = 1; rd_req = 1; rd_addr = 50; wr_req = 1; wr_addr = 60; wr_data = 32'hCAFE_F00D;
`ifdef ARB_STARVE_GUARD_EN
    first_wr = 0;
    for (int k = 1; k <= 20; k++) begin
      run_cycle();
      if (s_wr && first_wr == 0) first_wr = k;
      chk("starve_wr_gnt", s_wr, (k == MAX_WAIT + 1));
      chk("starve_rd_gnt", s_rd, (k != MAX_WAIT + 1));
    end
    chk("starve_first_wr", first_wr, MAX_WAIT + 1);
`else
    first_wr = 0;
    for (int k = 1; k <= 100; k++) begin
      run_cycle();
      if (s_wr) first_wr++;
    end
    chk("starve_wr_count", first_wr, 0);
    visible = 0;
    run_cycle();
    chk("starve_blank_wr_gnt", s_wr, 1);
`endif
    rd_req = 0; wr_req = 0; run_cycle(); run_cycle(); run_cycle();

    // Reset with reads in flight
    visible = 1; rd_req = 1; rd_addr = 20; run_cycle();
    rd_addr = 21; run_cycle();
    rd_req = 0;
    #2 rst = 1; #1;
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_wdata", ram_wdata, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    model_reset();
    @(negedge clk); rst = 0;
    for (int k = 0; k < 4; k++) run_cycle();

    // Randomized traffic honouring the hold-until-grant rule
    s_rd = 1; s_wr = 1;
    for (int i = 0; i < 3000; i++) begin
      visible = ($urandom_range(0, 3) != 0);
      if (!rd_req || s_rd) begin
        rd_req = $urandom_range(0, 1); rd_addr = ADDR_W'($urandom_range(0, 255));
      end
      if (!wr_req || s_wr) begin
        wr_req = ($urandom_range(0, 2) == 0); wr_addr = ADDR_W'($urandom_range(0, 255));
        wr_data = $urandom;
      end
      run_cycle();
    end
    rd_req = 0; wr_req = 0;
    for (int k = 0; k < 4; k++) run_cycle();
    chk("drain_queue_empty", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
